mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM/WB pipeline stage for the 5-stage core. It sits between the data-memory stage and register-file write-back. It adds the following over a plain MEM/WB latch:
- stall and flush control
- a valid bit
- in-stage write-back data selection
- a one-entry write-back history for late forwarding
- a retired-instruction counter

## Interface
Parameters:
- DATA_W, 32, width of PC-link, ALU result, memory read data and write-back data
- REG_W, 5, register-address width
- CNT_W, 32, retired-instruction counter width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold every WB-side register this cycle
- Flush  in  1  insert a bubble into WB this cycle; wins over Stall
- MValid  in  1  MEM-stage instruction is valid
- Mmemtoreg  in  1  select memory read data for write-back
- Mregwrite  in  1  instruction writes the register file
- Mcntrljalr  in  1  jalr: write link address
- Mcntrljald  in  1  jal: write link address
- MPCAddResult  in  DATA_W  PC+4 link value
- MAluResult  in  DATA_W  ALU result
- ReadDataOut  in  DATA_W  data-memory read data
- MRegDst  in  REG_W  destination register
- WBValid  out  1  WB-stage instruction valid
- WBregwrite  out  1  qualified register-file write enable
- WBcntrljalr  out  1  registered jalr flag
- WBcntrljald  out  1  registered jal flag
- WBRegDst  out  REG_W  destination register
- WBWriteData  out  DATA_W  selected write-back data
- HistValid  out  1  history entry holds a committed write
- HistRegDst  out  REG_W  register written by the previous committed instruction
- HistData  out  DATA_W  data written by the previous committed instruction
- RetireCount  out  CNT_W  instructions retired since reset

## Operation
- Write-data select, evaluated on the M-side inputs and registered. Priority order:
  - Mcntrljalr or Mcntrljald → MPCAddResult
  - else Mmemtoreg → ReadDataOut
  - else MAluResult
- Write qualification: WBregwrite loads MValid & Mregwrite & (MRegDst != 0). Register 0 is never written.
- Each rising edge, the WB stage behaves in priority order:
  1. Flush: WBValid, WBregwrite, WBcntrljalr and WBcntrljald clear to 0. WBRegDst and WBWriteData hold.
  2. Stall: all WB outputs hold.
  3. Otherwise: load all WB outputs from the M side. WBValid loads MValid.
- The stage "advances" on any edge where Stall = 0 or Flush = 1.
- History register, on each advancing edge:
  - HistValid loads WBValid & WBregwrite, using the current values before the edge.
  - HistRegDst and HistData load WBRegDst and WBWriteData.
  - It holds on non-advancing edges.
- RetireCount increments by 1 on each advancing edge where the current WBValid = 1. Flush does not cancel the instruction already in WB: that instruction still retires on the flush edge.
- RetireCount is modulo 2^CNT_W and wraps silently from all-ones to 0.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle from M-side inputs to WB outputs, and 2 cycles from M-side inputs to the history outputs.
- Reset: while Reset is high, every output is forced to 0 immediately, without waiting for a clock edge. This covers:
  - WBValid, WBregwrite, WBcntrljalr, WBcntrljald
  - WBRegDst, WBWriteData
  - HistValid, HistRegDst, HistData
  - RetireCount
- The first load after Reset deasserts happens at the first rising edge where Reset is low.
- Reset asserted mid-stall or mid-flush: all state clears, and nothing already in WB retires.
- Flush and Stall both high: Flush behaviour applies, and history and counter advance.
- Stall held for N cycles: WB outputs are stable for N+1 cycles. The register file sees a repeated, idempotent write. RetireCount counts the instruction once, on its release edge.
- MValid = 0 with Mregwrite = 1: the bubble loads with WBregwrite = 0. HistValid = 0 after the next advance. RetireCount does not count it.

## Test plan
- Reset check: drive Reset high asynchronously mid-cycle with non-zero state → all outputs 0 before the next edge; first load occurs at the first edge with Reset low.
- Select priority: drive in successive cycles
  - alu: MAluResult = 0x11, ReadDataOut = 0x22, MPCAddResult = 0x33, Mmemtoreg = 0
  - load: Mmemtoreg = 1
  - jal: Mmemtoreg = 1, Mcntrljald = 1

  → WBWriteData is 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its input.
- r0 guard: MValid = 1, Mregwrite = 1, MRegDst = 0 → WBregwrite = 0, WBValid = 1; next advance gives HistValid = 0 and RetireCount +1.
- Stall/history: load write to r5 with data 0xABCD, then Stall for 3 cycles → WB outputs hold for 4 cycles in total. After release, HistRegDst = 5, HistData = 0xABCD, HistValid = 1, and RetireCount has incremented exactly once.
- Flush with stall: Flush = 1 and Stall = 1 with a valid r7 write in WB → WBValid = 0 and WBregwrite = 0 next cycle; history captures r7; RetireCount +1.
- Counter wrap: CNT_W = 4, retire 17 valid instructions → RetireCount = 1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register for the 5-stage core. Besides latching the MEM-side
// control and data into the write-back stage, it:
//   - selects the write-back data (link address, load data or ALU result)
//     before the register, so WB sees a single ready-to-write value
//   - qualifies the register-file write with the valid bit and a register-0
//     guard
//   - supports Stall (hold) and Flush (bubble insertion; Flush wins)
//   - keeps a one-entry history of the previous committed write so that a
//     late consumer can still forward from it
//   - counts retired instructions (modulo 2^CNT_W)
//
// Parameters
//   DATA_W : width of PC link, ALU result, memory read data and write data
//   REG_W  : register-address width
//   CNT_W  : retired-instruction counter width
//
// Ports
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-high reset, clears every output
//   Stall        in   hold every WB-side register this cycle
//   Flush        in   insert a bubble into WB this cycle (wins over Stall)
//   MValid       in   MEM-stage instruction is valid
//   Mmemtoreg    in   select memory read data for write-back
//   Mregwrite    in   instruction writes the register file
//   Mcntrljalr   in   jalr: write link address
//   Mcntrljald   in   jal: write link address
//   MPCAddResult in   PC+4 link value
//   MAluResult   in   ALU result
//   ReadDataOut  in   data-memory read data
//   MRegDst      in   destination register
//   WBValid      out  WB-stage instruction valid
//   WBregwrite   out  qualified register-file write enable
//   WBcntrljalr  out  registered jalr flag
//   WBcntrljald  out  registered jal flag
//   WBRegDst     out  destination register
//   WBWriteData  out  selected write-back data
//   HistValid    out  history entry holds a committed write
//   HistRegDst   out  register written by the previous committed instruction
//   HistData     out  data written by the previous committed instruction
//   RetireCount  out  instructions retired since reset
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              MValid,
    input  logic              Mmemtoreg,
    input  logic              Mregwrite,
    input  logic              Mcntrljalr,
    input  logic              Mcntrljald,
    input  logic [DATA_W-1:0] MPCAddResult,
    input  logic [DATA_W-1:0] MAluResult,
    input  logic [DATA_W-1:0] ReadDataOut,
    input  logic [REG_W-1:0]  MRegDst,
    output logic              WBValid,
    output logic              WBregwrite,
    output logic              WBcntrljalr,
    output logic              WBcntrljald,
    output logic [REG_W-1:0]  WBRegDst,
    output logic [DATA_W-1:0] WBWriteData,
    output logic              HistValid,
    output logic [REG_W-1:0]  HistRegDst,
    output logic [DATA_W-1:0] HistData,
    output logic [CNT_W-1:0]  RetireCount
);

    logic [DATA_W-1:0] selData;
    logic              qualWrite;
    logic              advance;
    logic              commitWrite;

    // Write-back data select on the M side. Jumps write the link address even
    // if memtoreg happens to be set, so the link check comes first.
    always_comb begin
        selData = MAluResult;
        if (Mcntrljalr || Mcntrljald) begin
            selData = MPCAddResult;
        end else if (Mmemtoreg) begin
            selData = ReadDataOut;
        end
    end

    // Register 0 is hard-wired to zero, so a write to it is dropped here
    // rather than relying on the register file to ignore it.
    assign qualWrite = MValid & Mregwrite & (MRegDst != '0);

    // The stage moves on whenever it is not stalled; a flush always moves it,
    // because the bubble replaces whatever was being held.
    assign advance = ~Stall | Flush;

    // Only a valid instruction that really wrote a register is worth
    // remembering for late forwarding.
    assign commitWrite = WBValid & WBregwrite;

    // Control half of the WB register. Flush clears the control bits only;
    // the destination and data are left alone since nothing consumes them
    // without a valid write enable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WBValid     <= 1'b0;
            WBregwrite  <= 1'b0;
            WBcntrljalr <= 1'b0;
            WBcntrljald <= 1'b0;
        end else if (Flush) begin
            WBValid     <= 1'b0;
            WBregwrite  <= 1'b0;
            WBcntrljalr <= 1'b0;
            WBcntrljald <= 1'b0;
        end else if (!Stall) begin
            WBValid     <= MValid;
            WBregwrite  <= qualWrite;
            WBcntrljalr <= Mcntrljalr;
            WBcntrljald <= Mcntrljald;
        end
    end

    // Data half of the WB register: holds on both stall and flush.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WBRegDst    <= '0;
            WBWriteData <= '0;
        end else if (!Flush && !Stall) begin
            WBRegDst    <= MRegDst;
            WBWriteData <= selData;
        end
    end

    // History entry captures what WB held just before it advanced, so it
    // trails the WB outputs by one advance.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            HistValid  <= 1'b0;
            HistRegDst <= '0;
            HistData   <= '0;
        end else if (advance) begin
            HistValid  <= commitWrite;
            HistRegDst <= WBRegDst;
            HistData   <= WBWriteData;
        end
    end

    // An instruction retires when it leaves WB. A flush only cancels what is
    // coming in from MEM, so the instruction already in WB still counts.
    // Stalled edges do not count, so a held instruction retires exactly once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RetireCount <= '0;
        end else if (advance && WBValid) begin
            RetireCount <= RetireCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed bench for mem_wb_stage. Two instances share every input: one with
// the default 32-bit retire counter and one with a 4-bit counter for the wrap
// check. Expected values are worked out by hand for each step.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        MValid;
    logic        Mmemtoreg;
    logic        Mregwrite;
    logic        Mcntrljalr;
    logic        Mcntrljald;
    logic [31:0] MPCAddResult;
    logic [31:0] MAluResult;
    logic [31:0] ReadDataOut;
    logic [4:0]  MRegDst;

    logic        WBValid, WBregwrite, WBcntrljalr, WBcntrljald;
    logic [4:0]  WBRegDst;
    logic [31:0] WBWriteData;
    logic        HistValid;
    logic [4:0]  HistRegDst;
    logic [31:0] HistData;
    logic [31:0] RetireCount;

    logic        wValid, wRegwrite, wJalr, wJald;
    logic [4:0]  wRegDst;
    logic [31:0] wWriteData;
    logic        wHistValid;
    logic [4:0]  wHistRegDst;
    logic [31:0] wHistData;
    logic [3:0]  wRetireCount;

    int vecCount  = 0;
    int missCount = 0;

    mem_wb_stage dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .MValid(MValid), .Mmemtoreg(Mmemtoreg), .Mregwrite(Mregwrite),
        .Mcntrljalr(Mcntrljalr), .Mcntrljald(Mcntrljald),
        .MPCAddResult(MPCAddResult), .MAluResult(MAluResult),
        .ReadDataOut(ReadDataOut), .MRegDst(MRegDst),
        .WBValid(WBValid), .WBregwrite(WBregwrite),
        .WBcntrljalr(WBcntrljalr), .WBcntrljald(WBcntrljald),
        .WBRegDst(WBRegDst), .WBWriteData(WBWriteData),
        .HistValid(HistValid), .HistRegDst(HistRegDst), .HistData(HistData),
        .RetireCount(RetireCount)
    );

    mem_wb_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dutw (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .MValid(MValid), .Mmemtoreg(Mmemtoreg), .Mregwrite(Mregwrite),
        .Mcntrljalr(Mcntrljalr), .Mcntrljald(Mcntrljald),
        .MPCAddResult(MPCAddResult), .MAluResult(MAluResult),
        .ReadDataOut(ReadDataOut), .MRegDst(MRegDst),
        .WBValid(wValid), .WBregwrite(wRegwrite),
        .WBcntrljalr(wJalr), .WBcntrljald(wJald),
        .WBRegDst(wRegDst), .WBWriteData(wWriteData),
        .HistValid(wHistValid), .HistRegDst(wHistRegDst), .HistData(wHistData),
        .RetireCount(wRetireCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drives the M-side instruction fields.
    task automatic applyStimulus(input logic valid, input logic memtoreg,
                                 input logic regwrite, input logic jalr,
                                 input logic jald, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] rd,
                                 input logic [4:0] dst);
        MValid       = valid;
        Mmemtoreg    = memtoreg;
        Mregwrite    = regwrite;
        Mcntrljalr   = jalr;
        Mcntrljald   = jald;
        MPCAddResult = pc;
        MAluResult   = alu;
        ReadDataOut  = rd;
        MRegDst      = dst;
    endtask

    // One clock, sampling 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // WB outputs of the main instance.
    task automatic checkWb(input string tag, input logic valid, input logic rw,
                           input logic jalr, input logic jald,
                           input logic [4:0] dst, input logic [31:0] data);
        checkOutput({tag, ".WBValid"},     64'(WBValid),     64'(valid));
        checkOutput({tag, ".WBregwrite"},  64'(WBregwrite),  64'(rw));
        checkOutput({tag, ".WBcntrljalr"}, 64'(WBcntrljalr), 64'(jalr));
        checkOutput({tag, ".WBcntrljald"}, 64'(WBcntrljald), 64'(jald));
        checkOutput({tag, ".WBRegDst"},    64'(WBRegDst),    64'(dst));
        checkOutput({tag, ".WBWriteData"}, 64'(WBWriteData), 64'(data));
    endtask

    task automatic checkHist(input string tag, input logic valid,
                             input logic [4:0] dst, input logic [31:0] data);
        checkOutput({tag, ".HistValid"},  64'(HistValid),  64'(valid));
        checkOutput({tag, ".HistRegDst"}, 64'(HistRegDst), 64'(dst));
        checkOutput({tag, ".HistData"},   64'(HistData),   64'(data));
    endtask

    // Both counters: full width and the 4-bit wrapping one.
    task automatic checkCount(input string tag, input int expected);
        checkOutput({tag, ".RetireCount"},  64'(RetireCount),  64'(expected));
        checkOutput({tag, ".RetireCount4"}, 64'(wRetireCount), 64'(expected % 16));
    endtask

    task automatic checkAllZero(input string tag);
        checkWb(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkHist(tag, 1'b0, 5'd0, 32'h0);
        checkCount(tag, 0);
        checkOutput({tag, ".w.WBValid"},    64'(wValid),     64'h0);
        checkOutput({tag, ".w.WBWriteData"}, 64'(wWriteData), 64'h0);
        checkOutput({tag, ".w.HistData"},   64'(wHistData),  64'h0);
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        // alu vector already waiting while reset is held
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h33, 32'h11, 32'h22, 5'd1);
        #3;
        checkAllZero("reset_t3");
        tick();
        checkAllZero("reset_edge");
        Reset = 1'b0;

        // select priority: alu, load, jal, jalr
        tick();
        checkWb("sel_alu", 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h11);
        checkCount("sel_alu", 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h33, 32'h11, 32'h22, 5'd2);
        tick();
        checkWb("sel_load", 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h22);
        checkHist("sel_load", 1'b1, 5'd1, 32'h11);
        checkCount("sel_load", 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h33, 32'h11, 32'h22, 5'd3);
        tick();
        checkWb("sel_jal", 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33);
        checkHist("sel_jal", 1'b1, 5'd2, 32'h22);
        checkCount("sel_jal", 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h11, 32'h22, 5'd4);
        tick();
        checkWb("sel_jalr", 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h44);
        checkCount("sel_jalr", 3);

        // r0 guard
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h55, 32'h0, 5'd0);
        tick();
        checkWb("r0", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h55);
        checkHist("r0", 1'b1, 5'd4, 32'h44);
        checkCount("r0", 4);

        // bubble with regwrite set
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h66, 32'h0, 5'd6);
        tick();
        checkWb("bubble", 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 32'h66);
        checkHist("r0_hist", 1'b0, 5'd0, 32'h55);
        checkCount("bubble", 5);

        // load to r5, then three stalled cycles
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h77, 32'hABCD, 5'd5);
        tick();
        checkWb("ld_r5", 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hABCD);
        checkHist("bubble_hist", 1'b0, 5'd6, 32'h66);
        checkCount("ld_r5", 5);
        Stall = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h99, 32'h1234, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkWb($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hABCD);
            checkHist($sformatf("stall%0d", i), 1'b0, 5'd6, 32'h66);
            checkCount($sformatf("stall%0d", i), 5);
        end
        Stall = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h7777, 32'h0, 5'd7);
        tick();
        checkWb("release", 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h7777);
        checkHist("release", 1'b1, 5'd5, 32'hABCD);
        checkCount("release", 6);

        // flush together with stall while r7 sits in WB
        Flush = 1'b1;
        Stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h88, 32'h0, 5'd8);
        tick();
        checkWb("flush", 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h7777);
        checkHist("flush", 1'b1, 5'd7, 32'h7777);
        checkCount("flush", 7);
        Flush = 1'b0;
        Stall = 1'b0;
        tick();
        checkWb("after_flush", 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h88);
        checkHist("after_flush", 1'b0, 5'd7, 32'h7777);
        checkCount("after_flush", 7);

        // reset mid-stall with a valid instruction in WB
        Stall = 1'b1;
        tick();
        checkWb("pre_reset", 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h88);
        #2;
        Reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        #2;
        Reset = 1'b0;
        Stall = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h99, 32'h0, 5'd9);
        tick();
        checkWb("first_load", 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99);
        checkHist("first_load", 1'b0, 5'd0, 32'h0);
        checkCount("first_load", 0);

        // 17 retirements: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        checkCount("wrap", 17);
        checkOutput("wrap.RetireCount4_is_1", 64'(wRetireCount), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
